game_navigator: RTL and testbench

- Upstream control stage of the VGA game renderer; produces the navigation/options fields of the game state that the renderer consumes (state name, selected element, PIX_W, PIX_H).
- Synchronises and debounces four raw board buttons, then runs the menu state machine.
- Publishes its results only at a frame boundary, so the renderer never sees a mid-frame change.

---
 rtl/game_navigator.sv | 175 +++++++++++++++++
 tb/tb_game_navigator.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_navigator.sv
// game_navigator: menu/navigation front end for the VGA game renderer.
// Synchronises and debounces four active-low buttons, turns debounced
// presses into prioritised navigation events, keeps a shadow copy of the
// menu state, and publishes that copy only on frame_sync so the renderer
// never sees a mid-frame change.
//
// Ports:
//   clk              rising-edge clock
//   nreset           synchronous active-low reset
//   btn_*_n          raw active-low buttons (asynchronous to clk)
//   frame_sync       publish strobe (start of vertical blanking)
//   state_name       0=MAIN_MENU 1=OPTIONS 2=PLAY 3=HIGHSCORES
//   selected_element highlighted entry on the current screen
//   pix_w, pix_h     pixel scale factors, 1..PIX_MAX
//   state_changed    one-cycle pulse when a publish altered any output
module game_navigator #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int PIX_MAX         = 4,
  parameter int PIX_DEFAULT     = 2
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  input  logic       btn_select_n,
  input  logic       btn_back_n,
  input  logic       frame_sync,
  output logic [1:0] state_name,
  output logic [3:0] selected_element,
  output logic [4:0] pix_w,
  output logic [4:0] pix_h,
  output logic       state_changed
);

  typedef enum logic [1:0] {
    MAIN_MENU  = 2'd0,
    OPTIONS    = 2'd1,
    PLAY       = 2'd2,
    HIGHSCORES = 2'd3
  } state_e;

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0] PIX_MAX_V = 5'(PIX_MAX);
  localparam logic [4:0] PIX_DEF_V = 5'(PIX_DEFAULT);

  // Bit order used throughout: 0=up 1=down 2=select 3=back.
  logic [3:0] raw;
  assign raw = {btn_back_n, btn_select_n, btn_down_n, btn_up_n};

  logic [3:0]       sync1_q, sync2_q, db_q, db_d, press_q, press_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  // Debounce: the counter only runs while the synchronised level disagrees
  // with the debounced level, so any bounce back restarts the count.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) db_d[i]  = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + 1'b1;
      end
      press_d[i] = db_q[i] & ~db_d[i];
    end
  end

  state_e     st_q, st_d, out_st_q;
  logic [3:0] sel_q, sel_d, out_sel_q;
  logic [4:0] pw_q, pw_d, ph_q, ph_d, out_pw_q, out_ph_q;
  logic       chg_q, chg_d;

  // Shadow FSM. The if/else chain order is the event priority:
  // back > select > up > down; losers in the same cycle are dropped.
  always_comb begin
    st_d  = st_q;
    sel_d = sel_q;
    pw_d  = pw_q;
    ph_d  = ph_q;
    case (st_q)
      MAIN_MENU: begin
        if (press_q[3]) begin
          // back does nothing here but still masks lower-priority events
        end else if (press_q[2]) begin
          case (sel_q)
            4'd0:    st_d = PLAY;
            4'd1:    st_d = OPTIONS;
            default: st_d = HIGHSCORES;
          endcase
          sel_d = 4'd0;
        end else if (press_q[0]) begin
          sel_d = (sel_q == 4'd0) ? 4'd2 : sel_q - 4'd1;
        end else if (press_q[1]) begin
          sel_d = (sel_q == 4'd2) ? 4'd0 : sel_q + 4'd1;
        end
      end
      OPTIONS: begin
        if (press_q[3] || (press_q[2] && sel_q == 4'd0)) begin
          st_d  = MAIN_MENU;
          sel_d = 4'd1;  // land on the OPTIONS entry
        end else if (press_q[2]) begin
          if (sel_q == 4'd1) pw_d = (pw_q == PIX_MAX_V) ? 5'd1 : pw_q + 5'd1;
          else               ph_d = (ph_q == PIX_MAX_V) ? 5'd1 : ph_q + 5'd1;
        end else if (press_q[0]) begin
          sel_d = (sel_q == 4'd0) ? 4'd2 : sel_q - 4'd1;
        end else if (press_q[1]) begin
          sel_d = (sel_q == 4'd2) ? 4'd0 : sel_q + 4'd1;
        end
      end
      PLAY: begin
        if (press_q[3]) begin
          st_d  = MAIN_MENU;
          sel_d = 4'd0;
        end
      end
      default: begin
        if (press_q[3]) begin
          st_d  = MAIN_MENU;
          sel_d = 4'd2;
        end
      end
    endcase
  end

  // Publish the end-of-cycle shadow value, so an event landing in the
  // frame_sync cycle is included.
  always_comb begin
    chg_d = frame_sync &&
            ({st_d, sel_d, pw_d, ph_d} != {out_st_q, out_sel_q, out_pw_q, out_ph_q});
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      db_q      <= '1;
      press_q   <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
      st_q      <= MAIN_MENU;
      sel_q     <= '0;
      pw_q      <= PIX_DEF_V;
      ph_q      <= PIX_DEF_V;
      out_st_q  <= MAIN_MENU;
      out_sel_q <= '0;
      out_pw_q  <= PIX_DEF_V;
      out_ph_q  <= PIX_DEF_V;
      chg_q     <= 1'b0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      press_q <= press_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
      st_q    <= st_d;
      sel_q   <= sel_d;
      pw_q    <= pw_d;
      ph_q    <= ph_d;
      if (frame_sync) begin
        out_st_q  <= st_d;
        out_sel_q <= sel_d;
        out_pw_q  <= pw_d;
        out_ph_q  <= ph_d;
      end
      chg_q <= chg_d;
    end
  end

  assign state_name       = out_st_q;
  assign selected_element = out_sel_q;
  assign pix_w            = out_pw_q;
  assign pix_h            = out_ph_q;
  assign state_changed    = chg_q;

endmodule

// File: tb/tb_game_navigator.sv
module tb_game_navigator;

  localparam int DB   = 4;
  localparam int PMAX = 4;
  localparam int PDEF = 2;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [3:0] btn_n = 4'hF;  // 0=up 1=down 2=select 3=back
  logic       frame_sync = 1'b0;
  logic [1:0] state_name;
  logic [3:0] selected_element;
  logic [4:0] pix_w, pix_h;
  logic       state_changed;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  game_navigator #(.DEBOUNCE_CYCLES(DB), .PIX_MAX(PMAX), .PIX_DEFAULT(PDEF)) dut (
    .clk(clk), .nreset(nreset),
    .btn_up_n(btn_n[0]), .btn_down_n(btn_n[1]),
    .btn_select_n(btn_n[2]), .btn_back_n(btn_n[3]),
    .frame_sync(frame_sync),
    .state_name(state_name), .selected_element(selected_element),
    .pix_w(pix_w), .pix_h(pix_h), .state_changed(state_changed)
  );

  typedef struct {
    logic [3:0] mask;
    bit         frame;
    int st, sel, pw, ph;
    bit chg;
  } vec_t;

  vec_t vecs[30];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int st, input int sel,
                         input int pw, input int ph, input int chg);
    chk({tag, ".state"}, int'(state_name), st);
    chk({tag, ".sel"},   int'(selected_element), sel);
    chk({tag, ".pix_w"}, int'(pix_w), pw);
    chk({tag, ".pix_h"}, int'(pix_h), ph);
    chk({tag, ".chg"},   int'(state_changed), chg);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] mask);
    btn_n = ~mask;
    cyc(8);
    btn_n = 4'hF;
    cyc(8);
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    cyc(1);
    frame_sync = 1'b0;
  endtask

  // Reference model of the menu rules.
  int m_st, m_sel, m_pw, m_ph;
  int p_st, p_sel, p_pw, p_ph;

  task automatic model_event(input logic [3:0] mask);
    int ev;
    ev = mask[3] ? 3 : mask[2] ? 2 : mask[0] ? 0 : mask[1] ? 1 : -1;
    if (ev < 0) return;
    if (m_st == 0) begin
      if (ev == 2) begin
        m_st  = (m_sel == 0) ? 2 : (m_sel == 1) ? 1 : 3;
        m_sel = 0;
      end else if (ev == 0) m_sel = (m_sel + 2) % 3;
      else if (ev == 1)     m_sel = (m_sel + 1) % 3;
    end else if (m_st == 1) begin
      if (ev == 3 || (ev == 2 && m_sel == 0)) begin
        m_st = 0; m_sel = 1;
      end else if (ev == 2 && m_sel == 1) m_pw = m_pw % PMAX + 1;
      else if (ev == 2)                   m_ph = m_ph % PMAX + 1;
      else if (ev == 0)                   m_sel = (m_sel + 2) % 3;
      else                                m_sel = (m_sel + 1) % 3;
    end else if (ev == 3) begin
      m_sel = (m_st == 2) ? 0 : 2;
      m_st  = 0;
    end
  endtask

  initial begin
    //          mask   frm st sel pw ph chg
    vecs[0]  = '{4'h1, 1, 0, 2, 2, 2, 1};  // up wraps 0->2
    vecs[1]  = '{4'h4, 1, 3, 0, 2, 2, 1};  // select -> HIGHSCORES
    vecs[2]  = '{4'h8, 1, 0, 2, 2, 2, 1};  // back -> MAIN sel=2
    vecs[3]  = '{4'h1, 1, 0, 1, 2, 2, 1};
    vecs[4]  = '{4'h4, 1, 1, 0, 2, 2, 1};  // enter OPTIONS
    vecs[5]  = '{4'h2, 1, 1, 1, 2, 2, 1};
    vecs[6]  = '{4'h4, 1, 1, 1, 3, 2, 1};
    vecs[7]  = '{4'h4, 1, 1, 1, 4, 2, 1};
    vecs[8]  = '{4'h4, 1, 1, 1, 1, 2, 1};  // pix_w wraps PIX_MAX->1
    vecs[9]  = '{4'h8, 1, 0, 1, 1, 2, 1};  // back -> MAIN sel=1
    vecs[10] = '{4'h4, 1, 1, 0, 1, 2, 1};
    vecs[11] = '{4'h2, 0, 1, 0, 1, 2, 0};  // no publish yet
    vecs[12] = '{4'h2, 1, 1, 2, 1, 2, 1};  // jumps 0->2
    vecs[13] = '{4'h0, 1, 1, 2, 1, 2, 0};  // publish with no change
    vecs[14] = '{4'hA, 1, 0, 1, 1, 2, 1};  // back beats down
    vecs[15] = '{4'h4, 1, 1, 0, 1, 2, 1};
    vecs[16] = '{4'h2, 1, 1, 1, 1, 2, 1};
    vecs[17] = '{4'h2, 1, 1, 2, 1, 2, 1};
    vecs[18] = '{4'h4, 1, 1, 2, 1, 3, 1};
    vecs[19] = '{4'h4, 1, 1, 2, 1, 4, 1};
    vecs[20] = '{4'h2, 1, 1, 0, 1, 4, 1};  // down wraps 2->0
    vecs[21] = '{4'h4, 1, 0, 1, 1, 4, 1};  // select on BACK entry
    vecs[22] = '{4'h2, 1, 0, 2, 1, 4, 1};
    vecs[23] = '{4'h4, 1, 3, 0, 1, 4, 1};
    vecs[24] = '{4'h4, 1, 3, 0, 1, 4, 0};  // select ignored in HIGHSCORES
    vecs[25] = '{4'h8, 1, 0, 2, 1, 4, 1};
    vecs[26] = '{4'h2, 1, 0, 0, 1, 4, 1};
    vecs[27] = '{4'h4, 1, 2, 0, 1, 4, 1};  // PLAY
    vecs[28] = '{4'h1, 1, 2, 0, 1, 4, 0};  // up ignored in PLAY
    vecs[29] = '{4'h8, 1, 0, 0, 1, 4, 1};  // back from PLAY -> sel=0

    cyc(2);
    nreset = 1'b1;
    cyc(1);
    chk_out("reset", 0, 0, PDEF, PDEF, 0);

    for (int i = 0; i < 30; i++) begin
      press(vecs[i].mask);
      if (vecs[i].frame) pulse_frame();
      else cyc(1);
      chk_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].sel,
              vecs[i].pw, vecs[i].ph, vecs[i].chg);
    end
    cyc(1);
    chk("vec_chg_one_cycle", int'(state_changed), 0);

    // Reset while btn_down is bouncing mid-debounce.
    btn_n[1] = 1'b0; cyc(3);
    btn_n[1] = 1'b1; cyc(1);
    btn_n[1] = 1'b0; cyc(2);
    nreset = 1'b0; cyc(1);
    nreset = 1'b1; btn_n[1] = 1'b1;
    chk_out("midreset", 0, 0, PDEF, PDEF, 0);
    cyc(12);
    pulse_frame();
    chk_out("midreset_noevent", 0, 0, PDEF, PDEF, 0);

    // Bounce rejection: toggle every 2 cycles, then hold low.
    for (int i = 0; i < 10; i++) begin
      btn_n[1] = i[0];
      cyc(2);
    end
    btn_n[1] = 1'b0; cyc(10);
    btn_n[1] = 1'b1; cyc(8);
    pulse_frame();
    chk_out("bounce", 0, 1, PDEF, PDEF, 1);
    cyc(1);
    chk("bounce_chg_drop", int'(state_changed), 0);

    // Event and frame_sync coincidence: up pressed; the publish one cycle
    // before the shadow update misses it, the next one includes it.
    btn_n[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1 frame_sync = 1'b1;
    cyc(1);
    chk_out("early_frame", 0, 1, PDEF, PDEF, 0);
    cyc(1);
    frame_sync = 1'b0;
    chk_out("same_cycle_frame", 0, 0, PDEF, PDEF, 1);
    btn_n[0] = 1'b1;
    cyc(8);

    // Randomized presses against the reference model.
    m_st = 0; m_sel = 0; m_pw = PDEF; m_ph = PDEF;
    p_st = 0; p_sel = 0; p_pw = PDEF; p_ph = PDEF;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] mask;
      if ($urandom_range(0, 3) != 0) mask = 4'(1 << $urandom_range(0, 3));
      else                           mask = 4'($urandom_range(0, 15));
      press(mask);
      model_event(mask);
      if ($urandom_range(0, 1) == 1 || i == 59) begin
        int chg;
        chg = (m_st != p_st || m_sel != p_sel || m_pw != p_pw || m_ph != p_ph) ? 1 : 0;
        pulse_frame();
        chk_out($sformatf("rnd%0d", i), m_st, m_sel, m_pw, m_ph, chg);
        p_st = m_st; p_sel = m_sel; p_pw = m_pw; p_ph = m_ph;
      end else begin
        chk($sformatf("rnd%0d_hold_sel", i), int'(selected_element), p_sel);
        chk($sformatf("rnd%0d_hold_st", i), int'(state_name), p_st);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
